prog_loader_encoder: RTL and testbench

- Program loader that sits upstream of instruction memory.
- Accepts symbolic instructions (ADDI, BNE, LW plus register and immediate fields) over a valid/ready handshake.
- Encodes each one into a 32-bit RV32I word and writes it sequentially into instruction memory through a single write port.
- It is the writer/encoder counterpart of the CPU's instruction decode path; words it produces must decode to identical control settings.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/rv_instr_encode.sv | 45 ++++
 rtl/prog_loader_encoder.sv | 146 ++++++++++++++
 tb/tb_prog_loader_encoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and enums, used by the program loader
// and by the CPU decoder.
package rv_pkg;

    typedef enum logic [1:0] {
        OP_ADDI = 2'd0,
        OP_BNE  = 2'd1,
        OP_LW   = 2'd2,
        OP_RSVD = 2'd3
    } op_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } ld_state_t;

    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;

endpackage

// File: rtl/rv_instr_encode.sv
// Combinational RV32I encoder for ADDI/BNE/LW; flags fields that cannot
// be represented (reserved op, I-immediate out of range, odd branch offset).
module rv_instr_encode
    import rv_pkg::*;
(
    input  op_kind_t    i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_reject
);

    logic w_i_range_bad;

    // imm is 13-bit signed; I-type only keeps 12 bits, so bit 12 must mirror bit 11
    assign w_i_range_bad = (i_imm[12] != i_imm[11]);

    // Field packing and legality per operation
    always_comb begin
        o_word   = 32'h0000_0000;
        o_reject = 1'b0;
        case (i_op)
            OP_ADDI: begin
                o_word   = {i_imm[11:0], i_rs1, F3_ADDI, i_rd, OPC_ITYPE};
                o_reject = w_i_range_bad;
            end
            OP_LW: begin
                o_word   = {i_imm[11:0], i_rs1, F3_LW, i_rd, OPC_LOAD};
                o_reject = w_i_range_bad;
            end
            OP_BNE: begin
                o_word   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BNE,
                            i_imm[4:1], i_imm[11], OPC_BRANCH};
                o_reject = i_imm[0];
            end
            default: begin
                o_word   = 32'h0000_0000;
                o_reject = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/prog_loader_encoder.sv
// Program loader: accepts symbolic instructions, encodes them and writes
// them sequentially into instruction memory, one word per two cycles.
module prog_loader_encoder
    import rv_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [12:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    ld_state_t         r_state, w_state_nxt;
    logic [ADDR_W:0]   r_len, w_len_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic              r_fin, w_fin_nxt;

    logic              w_ready;
    logic              w_accept;
    logic [31:0]       w_word;
    logic              w_reject;
    logic [ADDR_W:0]   w_len_inc;

    rv_instr_encode u_enc (
        .i_op     (op_kind_t'(op_kind)),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_imm    (imm),
        .o_word   (w_word),
        .o_reject (w_reject)
    );

    // Write pointer is the program length itself, so it can never run past DEPTH
    assign w_ready   = (r_state == ST_IDLE) && (r_len < DEPTH_W);
    assign w_accept  = in_valid && w_ready;
    assign w_len_inc = r_len + (ADDR_W+1)'(1);

    // Next-state and next-output logic; start overrides everything at the end
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_fin_nxt   = r_fin;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_reject) begin
                    w_state_nxt = ST_WRITE;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_len[ADDR_W-1:0];
                    w_wdata_nxt = w_word;
                    w_fin_nxt   = finish;
                end else if (finish) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = r_err | w_accept;
                end else begin
                    w_err_nxt   = r_err | w_accept;
                end
            end
            ST_WRITE: begin
                w_len_nxt = w_len_inc;
                w_fin_nxt = 1'b0;
                if ((w_len_inc == DEPTH_W) || r_fin || finish) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (start) begin
            w_state_nxt = ST_IDLE;
            w_len_nxt   = '0;
            w_we_nxt    = 1'b0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_fin_nxt   = 1'b0;
        end else begin
            w_fin_nxt   = w_fin_nxt;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0000_0000;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_fin   <= w_fin_nxt;
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign prog_len  = r_len;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_prog_loader_encoder.sv
// Self-checking bench for prog_loader_encoder: directed scenarios plus a
// randomized run against an arithmetic encoding/acceptance model.
module tb_prog_loader_encoder;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst, start, finish, in_valid, in_ready;
    logic [1:0]        op_kind;
    logic [4:0]        rd, rs1, rs2;
    logic [12:0]       imm;
    logic              mem_we, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   prog_len;

    int total = 0;
    int bad   = 0;

    prog_loader_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op_kind(op_kind),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .prog_len(prog_len), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: is this instruction representable?
    function automatic logic model_bad(input logic [1:0] op, input logic [12:0] im);
        int v;
        v = $signed(im);
        if (op == 2'd3) return 1'b1;
        if (op == 2'd1) return (v % 2) != 0;
        return (v < -2048) || (v > 2047);
    endfunction

    // Reference model: RV32I word built from field values with shifts and masks
    function automatic logic [31:0] model_word(input logic [1:0] op, input logic [4:0] d,
                                               input logic [4:0] s1, input logic [4:0] s2,
                                               input logic [12:0] im);
        int v;
        logic [31:0] u;
        v = $signed(im);
        u = v;
        case (op)
            2'd0: return ((u & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7) | 32'h13;
            2'd2: return ((u & 32'hFFF) << 20) | (32'(s1) << 15) | (32'h2 << 12)
                         | (32'(d) << 7) | 32'h03;
            2'd1: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
                         | (32'(s2) << 20) | (32'(s1) << 15) | (32'h1 << 12)
                         | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
            default: return 32'h0;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [12:0] im, input logic fin);
        in_valid = 1'b1; op_kind = op; rd = d; rs1 = s1; rs2 = s2; imm = im; finish = fin;
        cyc();
        in_valid = 1'b0; finish = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        op_kind = 2'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd0;
        cyc(); cyc();
        rst = 1'b0;
        total++;
        if ({mem_we, mem_addr, mem_wdata, prog_len, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs we=%0b addr=%0d wdata=%h len=%0d done=%0b err=%0b exp all 0",
                     mem_we, mem_addr, mem_wdata, prog_len, done, err);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_addi_basic();
        pulse_start();
        drive(2'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 5'd0, 32'h00500093}) begin
            bad++;
            $display("FAIL addi_write we=%0b addr=%0d wdata=%h exp 1/0/00500093", mem_we, mem_addr, mem_wdata);
        end
        cyc();
        total++;
        if (prog_len !== 6'd1 || mem_we !== 1'b0) begin
            bad++; $display("FAIL addi_len len=%0d we=%0b exp 1/0", prog_len, mem_we);
        end
    endtask

    task automatic test_lw_bne();
        pulse_start();
        drive(2'd2, 5'd2, 5'd1, 5'd0, 13'd4, 1'b0);
        total++;
        if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 5'd0, 32'h0040A103, 1'b0}) begin
            bad++;
            $display("FAIL lw_write we=%0b addr=%0d wdata=%h rdy=%0b exp 1/0/0040a103/0",
                     mem_we, mem_addr, mem_wdata, in_ready);
        end
        cyc();
        drive(2'd1, 5'd0, 5'd1, 5'd2, -13'sd8, 1'b0);
        total++;
        if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, 5'd1, 32'hFE209CE3, 1'b0}) begin
            bad++;
            $display("FAIL bne_write we=%0b addr=%0d wdata=%h rdy=%0b exp 1/1/fe209ce3/0",
                     mem_we, mem_addr, mem_wdata, in_ready);
        end
        cyc();
        total++;
        if (prog_len !== 6'd2) begin bad++; $display("FAIL lw_bne_len got=%0d exp=2", prog_len); end
    endtask

    task automatic test_reject();
        logic [1:0]  ops [3] = '{2'd3, 2'd1, 2'd0};
        logic [12:0] ims [3] = '{13'd0, 13'd3, 13'd2048};
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 5'd3, 5'd4, 5'd5, ims[i], 1'b0);
            total++;
            if (mem_we !== 1'b0 || err !== 1'b1 || prog_len !== 6'd0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reject_%0d we=%0b err=%0b len=%0d rdy=%0b exp 0/1/0/1",
                         i, mem_we, err, prog_len, in_ready);
            end
            cyc();
        end
    endtask

    task automatic test_fill();
        logic [12:0] im;
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            im = 13'(i * 37);
            drive(2'd0, 5'(i), 5'(i + 3), 5'd0, im, 1'b0);
            total++;
            if (mem_we !== 1'b1 || mem_addr !== 5'(i) ||
                mem_wdata !== model_word(2'd0, 5'(i), 5'(i + 3), 5'd0, im)) begin
                bad++;
                $display("FAIL fill_%0d we=%0b addr=%0d wdata=%h exp addr=%0d wdata=%h", i, mem_we,
                         mem_addr, mem_wdata, i, model_word(2'd0, 5'(i), 5'(i + 3), 5'd0, im));
            end
            cyc();
        end
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || prog_len !== 6'd32) begin
            bad++; $display("FAIL fill_full done=%0b rdy=%0b len=%0d exp 1/0/32", done, in_ready, prog_len);
        end
        drive(2'd0, 5'd1, 5'd1, 5'd0, 13'd1, 1'b0);
        total++;
        if (mem_we !== 1'b0 || prog_len !== 6'd32 || mem_addr !== 5'd31) begin
            bad++; $display("FAIL fill_extra we=%0b len=%0d addr=%0d exp 0/32/31", mem_we, prog_len, mem_addr);
        end
    endtask

    task automatic test_finish();
        pulse_start();
        drive(2'd3, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0);
        cyc();
        drive(2'd0, 5'd7, 5'd2, 5'd0, 13'd100, 1'b1);
        total++;
        if (mem_we !== 1'b1 || mem_wdata !== model_word(2'd0, 5'd7, 5'd2, 5'd0, 13'd100)) begin
            bad++; $display("FAIL finish_write we=%0b wdata=%h", mem_we, mem_wdata);
        end
        cyc();
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || prog_len !== 6'd1 || err !== 1'b1) begin
            bad++; $display("FAIL finish_done done=%0b rdy=%0b len=%0d err=%0b exp 1/0/1/1",
                            done, in_ready, prog_len, err);
        end
        pulse_start();
        total++;
        if (prog_len !== 6'd0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL finish_restart len=%0d done=%0b err=%0b rdy=%0b exp 0/0/0/1",
                            prog_len, done, err, in_ready);
        end
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0) begin
            bad++; $display("FAIL finish_idle done=%0b rdy=%0b we=%0b exp 1/0/0", done, in_ready, mem_we);
        end
    endtask

    task automatic test_abort_write(input logic use_rst);
        pulse_start();
        drive(2'd0, 5'd1, 5'd1, 5'd0, 13'd1, 1'b0);
        cyc();
        drive(2'd0, 5'd2, 5'd2, 5'd0, 13'd2, 1'b0);
        if (use_rst) rst = 1'b1; else start = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0;
        total++;
        if (mem_we !== 1'b0 || prog_len !== 6'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL abort_%s we=%0b len=%0d rdy=%0b exp 0/0/1",
                            use_rst ? "rst" : "start", mem_we, prog_len, in_ready);
        end
        drive(2'd0, 5'd9, 5'd9, 5'd0, 13'd9, 1'b0);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 5'd0) begin
            bad++; $display("FAIL abort_%s_next we=%0b addr=%0d exp 1/0",
                            use_rst ? "rst" : "start", mem_we, mem_addr);
        end
        cyc();
    endtask

    task automatic test_random();
        int exp_len;
        logic exp_err;
        logic [1:0] op;
        logic [4:0] d, s1, s2;
        logic [12:0] im;
        pulse_start();
        exp_len = 0;
        exp_err = 1'b0;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3));
            d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
            im = ($urandom_range(0, 1) == 0) ? 13'($urandom) : 13'($urandom_range(0, 1000) * 2);
            repeat ($urandom_range(0, 2)) cyc();
            drive(op, d, s1, s2, im, 1'b0);
            if (model_bad(op, im)) begin
                exp_err = 1'b1;
                total++;
                if (mem_we !== 1'b0 || err !== exp_err || prog_len !== 6'(exp_len)) begin
                    bad++; $display("FAIL rand_rej_%0d op=%0d imm=%h we=%0b err=%0b len=%0d exp 0/1/%0d",
                                    n, op, im, mem_we, err, prog_len, exp_len);
                end
            end else begin
                total++;
                if (mem_we !== 1'b1 || mem_addr !== 5'(exp_len) ||
                    mem_wdata !== model_word(op, d, s1, s2, im)) begin
                    bad++; $display("FAIL rand_wr_%0d op=%0d imm=%h we=%0b addr=%0d wdata=%h exp addr=%0d wdata=%h",
                                    n, op, im, mem_we, mem_addr, mem_wdata, exp_len,
                                    model_word(op, d, s1, s2, im));
                end
                exp_len++;
                cyc();
                total++;
                if (prog_len !== 6'(exp_len) || err !== exp_err) begin
                    bad++; $display("FAIL rand_len_%0d len=%0d err=%0b exp %0d/%0b",
                                    n, prog_len, err, exp_len, exp_err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi_basic();
        test_lw_bne();
        test_reject();
        test_fill();
        test_finish();
        test_abort_write(1'b0);
        test_abort_write(1'b1);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
